// File: rtl/arm_console_uart.sv
// arm_console_uart: memory-mapped console transmitter on the core's data bus.
// Bytes written to TXDATA go through a small FIFO into an 8N1 shifter; STATUS
// reports full/busy/sticky overflow/level, CTRL holds the drain-interrupt enable.
module arm_console_uart #(
    parameter logic [31:0] BASE_ADDR  = 32'hE000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_cen,
    input  logic        ram_wen,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_flag,
    input  logic [31:0] ram_wdata,
    output logic [31:0] ram_rdata,
    output logic        txd,
    output logic        irq_tx
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          LW      = AW + 1;
    localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         r_state;
    logic [15:0]    r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shreg;
    logic           r_txd;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_ie;
    logic           r_ovf;
    logic [31:0]    r_rdata;

    logic           w_hit;
    logic [1:0]     w_off;
    logic           w_wr;
    logic           w_rd;
    logic           w_push_req;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_full;
    logic           w_busy;
    logic [7:0]     w_head;
    logic [31:0]    w_status;
    logic           w_unused;

    // Address decode; accesses outside the 16-byte window touch nothing.
    assign w_hit      = ram_cen && (ram_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = ram_addr[3:2];
    assign w_wr       = w_hit && ram_wen;
    assign w_rd       = w_hit && !ram_wen;
    assign w_push_req = w_wr && (w_off == 2'd1) && ram_flag[0];

    // The shifter takes the head byte when idle or on the last STOP cycle, so
    // frames run back to back while data is queued.
    assign w_pop  = (r_level != '0) &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && (r_cnt == 16'd0)));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign w_push = w_push_req && ((r_level < LW'(FIFO_DEPTH)) || w_pop);
    assign w_drop = w_push_req && !w_push;
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_busy = (r_level != '0) || (r_state != S_IDLE);
    assign w_head = r_mem[r_rd_ptr];

    assign w_unused = ^{ram_flag[3:1], ram_wdata[31:8], ram_addr[1:0]};

    // STATUS word assembled from the current register values.
    always_comb begin
        w_status          = '0;
        w_status[0]       = w_full;
        w_status[1]       = w_busy;
        w_status[2]       = r_ovf;
        w_status[8 +: LW] = r_level;
    end

    // FIFO storage is data-only and needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= ram_wdata[7:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // 8N1 shifter: txd is a flop so the line is glitch-free and idles high in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shreg <= w_head;
                        r_cnt   <= CNT_MAX;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt   <= CNT_MAX;
                        r_bit   <= 3'd0;
                        r_txd   <= r_shreg[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt <= CNT_MAX;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shreg <= {1'b0, r_shreg[7:1]};
                            r_txd   <= r_shreg[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    if (r_cnt == 16'd0) begin
                        if (w_pop) begin
                            r_shreg <= w_head;
                            r_cnt   <= CNT_MAX;
                            r_txd   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    // Control/status registers; an overflow in the same cycle as a STATUS read wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_off == 2'd2) && ram_flag[0]) r_ie <= ram_wdata[0];
            if (w_drop)                                   r_ovf <= 1'b1;
            else if (w_rd && (w_off == 2'd0))             r_ovf <= 1'b0;
        end
    end

    // Registered read data; holds its value on anything but a read hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            case (w_off)
                2'd0:    r_rdata <= w_status;
                2'd2:    r_rdata <= {31'b0, r_ie};
                default: r_rdata <= '0;
            endcase
        end
    end

    assign ram_rdata = r_rdata;
    assign txd       = r_txd;
    assign irq_tx    = r_ie && (r_level == '0) && (r_state == S_IDLE);

endmodule

// File: doc/arm_console_uart.md
# arm_console_uart

Memory-mapped console transmitter that answers the ARM core's data-memory bus (`ram_cen`/`ram_wen`/`ram_addr`/`ram_flag`/`ram_wdata` → `ram_rdata`) at the console window `0xE000_0000`. It replaces the simulation-only character sink with synthesizable hardware. Bytes written to the TX data register pass through a small FIFO to an 8N1 serial shifter. A status register lets firmware poll for space, and an optional interrupt signals when the FIFO has drained.

## Interface
Parameters:
- `BASE_ADDR`, 32'hE000_0000, base of the 16-byte register window; decode on `ram_addr[31:4]`.
- `CLK_DIV`, 16, clock cycles per serial bit; legal range 2..65535.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ram_cen`  in  1  bus access strobe from the core.
- `ram_wen`  in  1  1 = write, 0 = read; qualified by `ram_cen`.
- `ram_addr`  in  32  byte address.
- `ram_flag`  in  4  byte-lane enables for writes.
- `ram_wdata`  in  32  write data.
- `ram_rdata`  out  32  registered read data.
- `txd`  out  1  serial output; idle high.
- `irq_tx`  out  1  level interrupt: `CTRL.ie` AND FIFO empty AND shifter idle.

## Operation
- Hit: `ram_cen & (ram_addr[31:4] == BASE_ADDR[31:4])`. Offset is `ram_addr[3:2]`. Accesses that miss change no state.
- Offset 0x0, STATUS (read-only):
  - bit0 `full`.
  - bit1 `busy` (FIFO non-empty or shifter not IDLE).
  - bit2 `ovf`, sticky.
  - bits[12:8] FIFO level.
  - All other bits 0.
  - A read returns `ovf` as set, then clears it. If an overflow occurs in the same cycle as the read, `ovf` stays set.
- Offset 0x4, TXDATA (write-only):
  - A write with `ram_flag[0]=1` pushes `ram_wdata[7:0]`.
  - Reads return 0.
- Offset 0x8, CTRL: bit0 `ie`. Written only when `ram_flag[0]=1`. Reads return `{31'b0, ie}`.
- Offset 0xC: reserved. Reads return 0; writes are ignored.
- Write ordering:
  - A push is accepted if `level < FIFO_DEPTH` or the shifter pops in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set.
  - Writes never stall the bus.
- Shifter FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd=1`. If the FIFO is non-empty, pop into `shreg`, load the baud counter to `CLK_DIV-1`, and go to START.
  - START: `txd=0` for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `txd=shreg[0]` for `CLK_DIV` cycles per bit, shifting right, 8 bits LSB-first; then go to STOP.
  - STOP: `txd=1` for `CLK_DIV` cycles. At the final cycle:
    - If the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- `txd` is registered (driven from a flop).
- FIFO level counter is `$clog2(FIFO_DEPTH)+1` bits. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values:
  - `ram_rdata = 0`, `txd = 1`, `irq_tx = 0`.
  - FSM in IDLE, FIFO empty, `ie = 0`, `ovf = 0`.
- Read latency is 1 cycle. `ram_rdata` updates at the rising edge that samples a read hit and holds its value otherwise, including on misses and writes.
- A push accepted at edge k into an empty FIFO with the shifter IDLE produces a pop at edge k+1; `txd` falls after edge k+1.
- One frame is exactly 10·`CLK_DIV` cycles. Consecutive frames are contiguous while the FIFO is non-empty.
- `busy` falls, and `irq_tx` rises if `ie=1`, after the edge that ends the last STOP bit.
- `full` reflects the level after the current edge. A write arriving when full in the same cycle as a STOP-end pop is accepted.
- `rst_n` asserted mid-frame: `txd` returns to 1 immediately (asynchronously), the FIFO is discarded, and no partial frame resumes after release.

## Test plan
- Reset: hold `rst_n=0`, then release → `txd=1`, `ram_rdata=0`, `irq_tx=0`; a STATUS read returns 0x0000_0000.
- Single byte, `CLK_DIV=4`: write 0x55 to 0xE000_0004 at edge k → `txd` low for cycles k+1..k+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then high; total 40 cycles; STATUS bit1 reads 1 during the frame and 0 after.
- Back-to-back: write 0x41, 0x42, 0x43 in consecutive cycles → three contiguous frames (120 cycles at `CLK_DIV=4`), with no idle-high gap between the STOP of one frame and the START of the next.
- Overflow, `FIFO_DEPTH=8`: with the shifter busy, write 10 bytes in quick succession → STATUS shows level=8 with `full=1` and `ovf=1`; exactly 9 frames are transmitted; a second STATUS read shows `ovf=0`.
- Interrupt and lanes:
  - Write CTRL=1 with `ram_flag=4'b0001` → `irq_tx=1` while idle.
  - Write TXDATA → `irq_tx` drops after the pop and rises after the STOP bit ends.
  - Write TXDATA with `ram_flag=4'b1110` → no push occurs.
- Mid-frame reset and decode: assert `rst_n` during the DATA state → `txd=1` at once and the FIFO is empty after release. A read at 0xD000_0000 leaves `ram_rdata` unchanged.
